// File: rtl/input_event_pkg.sv
// Shared encodings and width helper for the input event arbiter.
package input_event_pkg;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

  // Channel index width; a two-or-fewer channel build still needs one bit.
  function automatic int ch_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/input_event_arbiter_if.sv
// Event stream handshake between the arbiter (master) and its consumer (slave).
interface input_event_arbiter_if #(
  parameter int N_CH = 4
);
  import input_event_pkg::*;

  localparam int CH_W = ch_w(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);

endinterface

// File: rtl/sync_debounce_ch.sv
// One channel: metastability synchronizer, debounce counter and accepted level.
// edge_o pulses combinationally on the cycle the new level is accepted.
module sync_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic edge_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // The counter only runs while the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    edge_o  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        edge_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/input_event_arbiter.sv
// Debounced multi-channel edge detector with one pending slot per channel,
// sticky overflow flags and a round-robin arbiter feeding a registered event port.
module input_event_arbiter
  import input_event_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             async_in,
  input  logic                        ovf_clr,
  output logic [N_CH-1:0]             level_out,
  output logic [N_CH-1:0]             ovf,
  input_event_arbiter_if.master       evt
);

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0] edge_s;
  logic [N_CH-1:0] new_dir;
  logic [N_CH-1:0] pend_valid_q, pend_valid_d;
  logic [N_CH-1:0] pend_rise_q, pend_rise_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] winner;
  logic            found;
  logic            load;
  logic            evt_valid_q, evt_valid_d;
  logic [CH_W-1:0] evt_ch_q, evt_ch_d;
  logic            evt_rise_q, evt_rise_d;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      sync_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (async_in[gi]),
        .level_o (level_out[gi]),
        .edge_o  (edge_s[gi])
      );
      // An accepted edge always moves the level to its complement.
      assign new_dir[gi] = level_out[gi] ? EVT_FALL : EVT_RISE;
    end
  endgenerate

  // First pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_CH;
      if (!found && pend_valid_q[idx]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  assign load  = !evt_valid_q || evt.evt_ready;
  assign grant = (load && found) ? (N_CH'(1) << winner) : '0;

  always_comb begin
    pend_valid_d = (pend_valid_q & ~grant) | edge_s;
    pend_rise_d  = (pend_rise_q & ~edge_s) | (new_dir & edge_s);
    // A fresh edge beats the clear so the loss is never hidden.
    ovf_d        = (ovf_clr ? '0 : ovf_q) | (edge_s & pend_valid_q & ~grant);
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    evt_rise_d   = evt_rise_q;
    rr_ptr_d     = rr_ptr_q;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d   = winner;
        evt_rise_d = pend_rise_q[winner];
        rr_ptr_d   = (winner == CH_W'(N_CH - 1)) ? '0 : winner + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= '0;
      pend_rise_q  <= '0;
      ovf_q        <= '0;
      rr_ptr_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      evt_rise_q   <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_rise_q  <= pend_rise_d;
      ovf_q        <= ovf_d;
      rr_ptr_q     <= rr_ptr_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      evt_rise_q   <= evt_rise_d;
    end
  end

  assign ovf           = ovf_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_rise  = evt_rise_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Bench for input_event_arbiter: directed scenarios with literal expectations
// plus a cycle-by-cycle comparison against a behavioural model.
module tb_input_event_arbiter;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] async_in;
  logic         ovf_clr;
  logic [N-1:0] level_out;
  logic [N-1:0] ovf;

  int n_vec = 0;
  int n_err = 0;

  input_event_arbiter_if #(.N_CH(N)) evt_if ();

  input_event_arbiter #(
    .N_CH            (N),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (async_in),
    .ovf_clr   (ovf_clr),
    .level_out (level_out),
    .ovf       (ovf),
    .evt       (evt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: input delay line, disagreement run length,
  // per-channel pending slot and a round-robin pick over the pending set.
  logic [N-1:0] m_hist[$];
  int           m_run[N];
  logic [N-1:0] m_level, m_pv, m_pr, m_ovf;
  logic         m_valid;
  int           m_ch;
  logic         m_rise;
  int           m_ptr;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_front('0);
    for (int c = 0; c < N; c++) m_run[c] = 0;
    m_level = '0; m_pv = '0; m_pr = '0; m_ovf = '0;
    m_valid = 1'b0; m_ch = 0; m_rise = 1'b0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [N-1:0] a, input logic rdy, input logic clr);
    logic [N-1:0] synced, edges, old_pv;
    int winner, granted;
    synced  = m_hist[S-1];
    edges   = '0;
    old_pv  = m_pv;
    granted = -1;
    for (int c = 0; c < N; c++) begin
      if (synced[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          edges[c]   = 1'b1;
          m_level[c] = synced[c];
          m_run[c]   = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    if (m_valid && rdy)
      $display("event delivered: ch=%0d rise=%0d t=%0t", m_ch, m_rise, $time);
    if (!m_valid || rdy) begin
      winner = -1;
      for (int k = 0; k < N; k++)
        if (winner < 0 && old_pv[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
      if (winner >= 0) begin
        m_valid = 1'b1;
        m_ch    = winner;
        m_rise  = m_pr[winner];
        m_ptr   = (winner + 1) % N;
        granted = winner;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (clr) m_ovf = '0;
    if (granted >= 0) m_pv[granted] = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (edges[c]) begin
        if (old_pv[c] && c != granted) m_ovf[c] = 1'b1;
        m_pv[c] = 1'b1;
        m_pr[c] = synced[c];
      end
    end
    m_hist.push_front(a);
    void'(m_hist.pop_back());
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step(async_in, evt_if.evt_ready, ovf_clr);
    #1;
    check("m_valid", evt_if.evt_valid, m_valid);
    if (m_valid) begin
      check("m_ch", evt_if.evt_ch, m_ch);
      check("m_rise", evt_if.evt_rise, m_rise);
    end
    check("m_level", level_out, m_level);
    check("m_ovf", ovf, m_ovf);
  end

  task automatic expect_evt(input string nm, input logic v, input int ch, input logic r);
    check({nm, "_valid"}, evt_if.evt_valid, v);
    if (v) begin
      check({nm, "_ch"}, evt_if.evt_ch, ch);
      check({nm, "_rise"}, evt_if.evt_rise, r);
    end
  endtask

  // Drive async_in and expect channels 0,1,3 on edges 7,8,9, then idle.
  task automatic burst(input string nm, input logic [N-1:0] val, input logic r);
    async_in = val;
    repeat (6) @(negedge clk);
    expect_evt({nm, "_e6"}, 1'b0, 0, 1'b0);
    @(negedge clk); expect_evt({nm, "_e7"}, 1'b1, 0, r);
    @(negedge clk); expect_evt({nm, "_e8"}, 1'b1, 1, r);
    @(negedge clk); expect_evt({nm, "_e9"}, 1'b1, 3, r);
    @(negedge clk); expect_evt({nm, "_e10"}, 1'b0, 0, 1'b0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; async_in = '0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    expect_evt("reset", 1'b0, 0, 1'b0);
    check("reset_level", level_out, 0);
    check("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single held rise on channel 2: event exactly 7 edges later, one cycle wide.
    async_in[2] = 1'b1;
    repeat (6) @(negedge clk);
    expect_evt("ch2_e6", 1'b0, 0, 1'b0);
    @(negedge clk);
    expect_evt("ch2_e7", 1'b1, 2, 1'b1);
    check("ch2_level", level_out[2], 1);
    @(negedge clk);
    expect_evt("ch2_e8", 1'b0, 0, 1'b0);
    async_in[2] = 1'b0;
    repeat (12) @(negedge clk);

    // Three-cycle glitch is filtered out.
    async_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    async_in[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("glitch_valid", evt_if.evt_valid, 0);
      check("glitch_level", level_out[0], 0);
    end

    // Four-cycle pulse just meets the debounce window.
    async_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    async_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    expect_evt("pulse4_rise", 1'b1, 0, 1'b1);
    repeat (4) @(negedge clk);
    expect_evt("pulse4_fall", 1'b1, 0, 1'b0);
    repeat (6) @(negedge clk);

    // Simultaneous edges, round-robin from pointer 0, back to back.
    reset_pulse();
    burst("rr_rise1", 4'b1011, 1'b1);
    burst("rr_fall",  4'b0000, 1'b0);
    burst("rr_rise2", 4'b1011, 1'b1);

    // Consumer stalled: output holds, repeated edges overflow channel 1.
    async_in = '0;
    reset_pulse();
    evt_if.evt_ready = 1'b0;
    async_in[1] = 1'b1;
    repeat (7) @(negedge clk);
    expect_evt("stall_first", 1'b1, 1, 1'b1);
    repeat (3) @(negedge clk);
    async_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_no_ovf_yet", ovf, 0);
    async_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    async_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_ovf", ovf, 4'b0010);
    expect_evt("stall_hold", 1'b1, 1, 1'b1);
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    expect_evt("stall_second", 1'b1, 1, 1'b0);
    @(negedge clk);
    expect_evt("stall_drained", 1'b0, 0, 1'b0);
    check("ovf_sticky", ovf, 4'b0010);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Reset while an event is presented and another is pending.
    evt_if.evt_ready = 1'b0;
    async_in = 4'b1100;
    repeat (9) @(negedge clk);
    expect_evt("pre_reset", 1'b1, 2, 1'b1);
    async_in = 4'b1000;
    #1 rst_n = 1'b0;
    #1;
    expect_evt("async_reset", 1'b0, 0, 1'b0);
    check("async_reset_ch", evt_if.evt_ch, 0);
    check("async_reset_rise", evt_if.evt_rise, 0);
    check("async_reset_level", level_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    expect_evt("post_reset_e6", 1'b0, 0, 1'b0);
    @(negedge clk);
    expect_evt("post_reset_e7", 1'b1, 3, 1'b1);
    @(negedge clk);
    expect_evt("post_reset_e8", 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
